// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display arbiter.
//   NUM_REQ          : number of requesters sharing the display
//   IDLE_BCD_DEFAULT : pattern shown with no owner (non-digit codes = dashes)
//   state_t          : arbiter states IDLE / OWN
//   rr_next()        : first set request index strictly after 'last', wrapping
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int          NUM_REQ          = 4;
   localparam logic [15:0] IDLE_BCD_DEFAULT = 16'hFFFF;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // Searches last+1, last+2, ... wrapping modulo NUM_REQ. Returns 'last'
   // when nothing is set; callers qualify the result with |req.
   function automatic logic [1:0] rr_next(input logic [NUM_REQ-1:0] req,
                                          input logic [1:0]         last);
      logic [1:0] idx;
      logic [1:0] j;
      logic       hit;
      idx = last;
      hit = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = last + 2'(k);
         if (!hit && req[j]) begin
            idx = j;
            hit = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin candidate search.
//   req   [3:0] in  : request levels
//   mask  [3:0] in  : requesters excluded from the search (current owner)
//   last  [1:0] in  : most recently granted index; search starts at last+1
//   found       out : some unmasked request is set
//   idx   [1:0] out : chosen requester, valid when found=1
// ---------------------------------------------------------------------------
module rr_picker
   import display_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [1:0]         last,
   output logic               found,
   output logic [1:0]         idx
);

   logic [NUM_REQ-1:0] w_cand;

   assign w_cand = req & ~mask;
   assign found  = |w_cand;
   assign idx    = rr_next(w_cand, last);

endmodule

// File: rtl/display_arbiter.sv
// ---------------------------------------------------------------------------
// display_arbiter
// Shares one 4-digit 7-segment driver among four requesters. Round-robin
// ownership with a minimum hold time; requester 0 preempts any other owner.
//   clk            in  : system clock, all logic on posedge
//   rst_n          in  : synchronous active-low reset
//   req      [3:0] in  : request levels, held while the display is wanted
//   bcd_in  [63:0] in  : requester i digits at bcd_in[16*i +: 16]
//   dp_in    [3:0] in  : decimal-point enable per requester
//   gnt      [3:0] out : one-hot grant, 0 when idle
//   owner    [1:0] out : current owner index, valid when active=1
//   active         out : some requester owns the display
//   bcd_out [15:0] out : digits to the display driver (registered)
//   en_dec_pt      out : decimal-point enable to the display driver
// ---------------------------------------------------------------------------
module display_arbiter
   import display_pkg::*;
#(
   parameter int          HOLD_CYCLES = 50_000_000,
   parameter logic [15:0] IDLE_BCD    = IDLE_BCD_DEFAULT
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [16*NUM_REQ-1:0] bcd_in,
   input  logic [NUM_REQ-1:0]   dp_in,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [1:0]           owner,
   output logic                 active,
   output logic [15:0]          bcd_out,
   output logic                 en_dec_pt
);

   localparam int            CW       = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

   state_t              r_state;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [1:0]          r_owner;
   logic [1:0]          r_last;
   logic [CW-1:0]       r_cnt;
   logic                r_active;
   logic [15:0]         r_bcd;
   logic                r_dp;

   logic [15:0]         w_slot [NUM_REQ];
   logic [NUM_REQ-1:0]  w_mask;
   logic                w_found;
   logic [1:0]          w_idx;
   logic                w_hold_done;
   logic                w_grant_new;
   logic                w_go_idle;
   logic [1:0]          w_next_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
         assign w_slot[gi] = bcd_in[16*gi +: 16];
      end
   endgenerate

   // While owning, r_last equals r_owner, so the same picker serves both the
   // idle search and the "next candidate after the owner" search.
   assign w_mask = (r_state == OWN) ? (NUM_REQ'(1) << r_owner) : '0;

   rr_picker u_picker (
      .req   (req),
      .mask  (w_mask),
      .last  (r_last),
      .found (w_found),
      .idx   (w_idx)
   );

   assign w_hold_done = (r_cnt == HOLD_MAX);

   always_comb begin
      w_grant_new = 1'b0;
      w_go_idle   = 1'b0;
      w_next_idx  = r_owner;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_grant_new = 1'b1;
               w_next_idx  = w_idx;
            end else begin
               w_go_idle = 1'b1;
            end
         end
         OWN: begin
            if (req[0] && (r_owner != 2'd0)) begin
               // urgent requester wins regardless of hold
               w_grant_new = 1'b1;
               w_next_idx  = 2'd0;
            end else if (!req[r_owner]) begin
               if (w_found) begin
                  w_grant_new = 1'b1;
                  w_next_idx  = w_idx;
               end else begin
                  w_go_idle = 1'b1;
               end
            end else if (w_hold_done && w_found) begin
               w_grant_new = 1'b1;
               w_next_idx  = w_idx;
            end
         end
         default: w_go_idle = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_gnt    <= '0;
         r_owner  <= 2'd0;
         r_last   <= 2'd3;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_bcd    <= IDLE_BCD;
         r_dp     <= 1'b0;
      end else if (w_grant_new) begin
         // grant and data source switch on the same edge
         r_state  <= OWN;
         r_gnt    <= NUM_REQ'(1) << w_next_idx;
         r_owner  <= w_next_idx;
         r_last   <= w_next_idx;
         r_cnt    <= '0;
         r_active <= 1'b1;
         r_bcd    <= w_slot[w_next_idx];
         r_dp     <= dp_in[w_next_idx];
      end else if (w_go_idle) begin
         r_state  <= IDLE;
         r_gnt    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_bcd    <= IDLE_BCD;
         r_dp     <= 1'b0;
      end else begin
         // owner keeps the display; counter saturates at HOLD_CYCLES-1
         if (!w_hold_done) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_bcd <= w_slot[r_owner];
         r_dp  <= dp_in[r_owner];
      end
   end

   assign gnt       = r_gnt;
   assign owner     = r_owner;
   assign active    = r_active;
   assign bcd_out   = r_bcd;
   assign en_dec_pt = r_dp;

endmodule

// File: tb/tb_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model of the arbitration rules (HOLD_CYCLES=4).
// ---------------------------------------------------------------------------
module tb_display_arbiter;

   localparam int HOLD = 4;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [63:0] bcd_in;
   logic [3:0]  dp_in;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        active;
   logic [15:0] bcd_out;
   logic        en_dec_pt;

   int n_vec;
   int n_err;
   int cyc;

   // behavioural model state
   int          m_active;
   int          m_owner;
   int          m_last;
   int          m_held;
   logic [15:0] m_bcd;
   logic        m_dp;

   display_arbiter #(.HOLD_CYCLES(HOLD), .IDLE_BCD(16'hFFFF)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .bcd_in    (bcd_in),
      .dp_in     (dp_in),
      .gnt       (gnt),
      .owner     (owner),
      .active    (active),
      .bcd_out   (bcd_out),
      .en_dec_pt (en_dec_pt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
      end
   endtask

   // first requester set after 'from' (wrapping), ignoring 'skip'; -1 if none
   function automatic int search(input logic [3:0] r, input int from, input int skip);
      for (int k = 1; k <= 4; k++) begin
         int j;
         j = (from + k) % 4;
         if (r[j] && j != skip) return j;
      end
      return -1;
   endfunction

   // Applies the arbitration rules to the inputs present at this clock edge.
   task automatic model_step();
      int nxt;
      bit fresh;
      if (!rst_n) begin
         m_active = 0; m_owner = 0; m_last = 3; m_held = 0;
         m_bcd = 16'hFFFF; m_dp = 1'b0;
         return;
      end
      fresh = 1'b1;
      if (m_active == 0) begin
         nxt = (req != 0) ? search(req, m_last, -1) : -1;
      end else if (req[0] && m_owner != 0) begin
         nxt = 0;
      end else if (!req[m_owner]) begin
         nxt = search(req, m_owner, m_owner);
      end else if (m_held >= HOLD - 1 && search(req, m_owner, m_owner) >= 0) begin
         nxt = search(req, m_owner, m_owner);
      end else begin
         nxt = m_owner;
         fresh = 1'b0;
      end
      if (nxt < 0) begin
         m_active = 0; m_held = 0;
         m_bcd = 16'hFFFF; m_dp = 1'b0;
      end else begin
         if (fresh) m_held = 0;
         else if (m_held < HOLD - 1) m_held++;
         m_active = 1; m_owner = nxt; m_last = nxt;
         m_bcd = bcd_in[16*nxt +: 16];
         m_dp  = dp_in[nxt];
      end
   endtask

   task automatic compare_all();
      logic [3:0] exp_gnt;
      exp_gnt = (m_active != 0) ? 4'(1 << m_owner) : 4'b0000;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("active", 32'(active), 32'(m_active));
      if (m_active != 0) check("owner", 32'(owner), 32'(m_owner));
      check("bcd_out", 32'(bcd_out), 32'(m_bcd));
      check("en_dec_pt", 32'(en_dec_pt), 32'(m_dp));
   endtask

   // one transaction: inputs already driven, clock edge, model, compare
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      $display("cyc %0d rst_n=%b req=%b gnt=%b owner=%0d bcd=%h dp=%b",
               cyc, rst_n, req, gnt, owner, bcd_out, en_dec_pt);
      compare_all();
   endtask

   task automatic randomize_data();
      bcd_in = {$urandom, $urandom};
      dp_in  = 4'($urandom);
   endtask

   initial begin
      int guard;
      n_vec = 0; n_err = 0; cyc = 0;
      m_active = 0; m_owner = 0; m_last = 3; m_held = 0;
      m_bcd = 16'hFFFF; m_dp = 1'b0;
      rst_n = 1'b0; req = 4'b1111; randomize_data();

      // reset with all requests pending
      cycle(); cycle();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_active", 32'(active), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_bcd", 32'(bcd_out), 32'hFFFF);
      check("rst_dp", 32'(en_dec_pt), 32'h0);
      rst_n = 1'b1;
      cycle();
      check("first_gnt", 32'(gnt), 32'h1);

      // single requester
      req = 4'b0000; cycle();
      req = 4'b0100; bcd_in[47:32] = 16'h1234; dp_in[2] = 1'b1;
      cycle();
      check("single_gnt", 32'(gnt), 32'h4);
      check("single_bcd", 32'(bcd_out), 32'h1234);
      check("single_dp", 32'(en_dec_pt), 32'h1);
      req = 4'b0000; cycle();
      check("single_rel_bcd", 32'(bcd_out), 32'hFFFF);

      // round robin with hold among 1..3
      req = 4'b1110;
      for (int i = 0; i < 14; i++) begin randomize_data(); cycle(); end

      // urgent preempt when owner 2 has held one cycle
      guard = 0;
      while (!(m_active != 0 && m_owner == 2 && m_held == 1) && guard < 40) begin
         randomize_data(); cycle(); guard++;
      end
      check("preempt_setup_timeout", 32'(guard < 40), 32'h1);
      req = 4'b1111; randomize_data();
      cycle();
      check("preempt_gnt", 32'(gnt), 32'h1);
      for (int i = 0; i < 6; i++) begin randomize_data(); cycle(); end

      // early release by owner 1 at cnt=0 while requester 3 waits
      req = 4'b1010;
      guard = 0;
      while (!(m_active != 0 && m_owner == 1 && m_held == 0) && guard < 40) begin
         randomize_data(); cycle(); guard++;
      end
      check("release_setup_timeout", 32'(guard < 40), 32'h1);
      req = 4'b1000; randomize_data();
      cycle();
      check("release_gnt", 32'(gnt), 32'h8);
      check("release_active", 32'(active), 32'h1);

      // reset mid-ownership
      cycle();
      rst_n = 1'b0; cycle();
      check("midrst_active", 32'(active), 32'h0);
      check("midrst_bcd", 32'(bcd_out), 32'hFFFF);
      rst_n = 1'b1; cycle();
      check("midrst_regnt", 32'(gnt), 32'h8);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         end
         rst_n = ($urandom_range(0, 99) != 0);
         randomize_data();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
